alu_sequencer: RTL

//  Multi-cycle control unit for the 8-bit Harvard core. It fetches 16-bit instructions from

---
 rtl/alu_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute control unit for the 8-bit Harvard core.
//   clk, rst (async, active-high) | run: execute enable, sampled at instruction boundaries
//   imem_addr/imem_data: instruction fetch port | alu_op/alu_in1/alu_in2/alu_result: ALU master port
//   dbg_sel/dbg_data: register-file peek | pc, zero, busy, halted: status
module alu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] OP_ADD   = 8'h01,
  parameter logic [7:0] OP_SUB   = 8'h02,
  parameter logic [7:0] OP_NONE  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  output logic [7:0]  alu_op,
  output logic [7:0]  alu_in1,
  output logic [7:0]  alu_in2,
  input  logic [7:0]  alu_result,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data,
  output logic [7:0]  pc,
  output logic        zero,
  output logic        busy,
  output logic        halted
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  state_t      r_state, w_state;
  logic [7:0]  r_pc, w_pc, w_pc_inc;
  logic [15:0] r_ir, w_ir;
  logic [7:0]  r_regs [4];
  logic [7:0]  w_regs [4];
  logic        r_zero, w_zero;
  logic [7:0]  r_alu_op, w_alu_op, r_in1, w_in1, r_in2, w_in2;
  logic [3:0]  w_opc;
  logic [1:0]  w_rd, w_rs;
  logic [7:0]  w_imm;
  assign {w_opc, w_rd, w_rs, w_imm} = r_ir;
  assign w_pc_inc  = r_pc + 8'd1;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign zero      = r_zero;
  assign alu_op    = r_alu_op;
  assign alu_in1   = r_in1;
  assign alu_in2   = r_in2;
  assign dbg_data  = r_regs[dbg_sel];
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted    = (r_state == S_HALT);
  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_ir     = r_ir;
    w_regs   = r_regs;
    w_zero   = r_zero;
    w_alu_op = r_alu_op;
    w_in1    = r_in1;
    w_in2    = r_in2;
    case (r_state)
      S_IDLE:  w_state = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        w_ir    = imem_data;
        w_state = S_DECODE;
      end
      S_DECODE: begin
        w_state = run ? S_FETCH : S_IDLE;
        case (w_opc)
          4'h1, 4'h2: begin
            // operands latched from pre-instruction regs, so rd==rs reads the old value
            w_alu_op = (w_opc == 4'h1) ? OP_ADD : OP_SUB;
            w_in1    = r_regs[w_rd];
            w_in2    = r_regs[w_rs];
            w_state  = S_EXEC;
          end
          4'h3: begin
            w_regs[w_rd] = w_imm;
            w_zero       = (w_imm == 8'h00);
            w_pc         = w_pc_inc;
          end
          4'h4:    w_pc = w_imm;
          4'h5:    w_pc = r_zero ? w_imm : w_pc_inc;
          4'hF:    w_state = S_HALT;
          default: w_pc = w_pc_inc;
        endcase
      end
      // drop the op after one cycle so the registered ALU holds its result for WB
      S_EXEC: begin
        w_alu_op = OP_NONE;
        w_state  = S_WB;
      end
      S_WB: begin
        w_regs[w_rd] = alu_result;
        w_zero       = (alu_result == 8'h00);
        w_pc         = w_pc_inc;
        w_state      = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  w_state = S_HALT;
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_regs   <= '{default: '0};
      r_zero   <= 1'b0;
      r_alu_op <= OP_NONE;
      r_in1    <= '0;
      r_in2    <= '0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_ir     <= w_ir;
      r_regs   <= w_regs;
      r_zero   <= w_zero;
      r_alu_op <= w_alu_op;
      r_in1    <= w_in1;
      r_in2    <= w_in2;
    end
  end
endmodule
